arith_unit_mc: RTL and testbench
================================

// Module: arith_unit_mc
// PURPOSE
//  Multi-cycle successor of the ALU arithmetic unit: add/sub/mul/div on Width-bit operands, with a valid/ready handshake.
//  Add/sub/mul finish in one cycle. Div is an iterative restoring divider that also returns the remainder.
//  Sits under the ALU top, beside the logic/shift/compare units. The ALU decoder drives arith_enable/alu_fun.
// PARAMETERS
//  Width    16  operand/result width, >=4
//  CNT_W    $clog2(Width+1)  divider iteration counter width (derived, not overridden)
// PORTS
//  CLK           in   1        single clock, all flops rising edge
//  RST           in   1        asynchronous, active-low reset
//  arith_enable  in   1        request valid; accepted when arith_enable & arith_ready at posedge CLK
//  alu_fun       in   2        00 add, 01 sub, 10 mul, 11 div
//  A, B          in   Width    operands, unsigned
//  arith_ready   out  1        unit can accept a request this cycle
//  arith_out     out  Width    sum/diff, product[Width-1:0], or quotient
//  arith_hi      out  Width    product[2W-1:W], remainder for div, 0 for add/sub
//  carry_out     out  1        add carry; sub borrow (A<B); 0 for mul/div
//  div_zero      out  1        div with B==0
//  arith_flag    out  1        result valid, one-cycle pulse
// BEHAVIOUR
//  Reset: arith_out=0, arith_hi=0, carry_out=0, div_zero=0, arith_flag=0, arith_ready=1, FSM=IDLE.
//  FSM states IDLE, DIV, DONE:
//   IDLE: arith_ready=1. On accept of add/sub/mul, results are registered at the same edge and arith_flag=1 in the next cycle (latency 1). The FSM stays in IDLE, so back-to-back requests are allowed every cycle.
//   IDLE, accept div, B!=0: latch A/B, clear the remainder register, count=Width, go to DIV, arith_ready=0.
//   IDLE, accept div, B==0: no iteration. Next cycle arith_flag=1, div_zero=1, arith_out=all ones, arith_hi=A.
//   DIV: each cycle shift {rem,quo} left 1 and trial-subtract B; a quotient bit is set if no borrow. count-- each cycle.
//        When count reaches 0 -> DONE. arith_enable is ignored while in DIV.
//   DONE: registers outputs, arith_flag=1 for exactly one cycle, arith_ready=1 -> IDLE.
//        A request presented in DONE is accepted.
//  Div latency: accept edge to arith_flag high = Width+1 cycles.
//  Width rules: add/sub computed at Width+1 bits, with the MSB going to carry_out. mul is computed at 2*Width bits.
//  arith_out/arith_hi/carry_out/div_zero hold their last values between pulses. div_zero clears on the next accepted result.
//  alu_fun, A and B are sampled only at accept. Later changes do not affect an in-flight div.
//  Async reset mid-div aborts the operation. No arith_flag pulse follows. The unit returns to IDLE with ready=1.
//  arith_enable=0: no state change, and arith_flag stays 0.
// CONFIGURATION
//  ARITH_SAT_EN defined: add overflow forces arith_out to all ones, and sub borrow forces arith_out=0. carry_out is still reported.
//   mul overflow (hi!=0) forces arith_out to all ones, and arith_hi keeps the true upper half.
//  ARITH_SAT_EN undefined: add/sub/mul wrap modulo 2^Width, with the same carry_out/arith_hi reporting.
// STRUCTURE
//  Shared package arith_pkg:
//   - opcode localparams ARITH_ADD/SUB/MUL/DIV
//   - FSM state encoding ST_IDLE/ST_DIV/ST_DONE (2-bit)
//  Sub-module arith_div_seq (Width param): start/busy/done, quo, rem. It holds the shift/subtract datapath and counter.
//  The top holds the handshake, FSM, single-cycle ops and output registers.
// TESTING (Width=16)
//  add A=16'hFFFF, B=16'h0001 -> next cycle arith_flag=1, arith_out=16'h0000, carry_out=1
//   (ARITH_SAT_EN: arith_out=16'hFFFF)
//  sub A=5, B=7 -> arith_out=16'hFFFE, carry_out=1 (ARITH_SAT_EN: 0)
//  mul A=16'h1234, B=16'h0100 -> arith_out=16'h3400, arith_hi=16'h0012, latency 1
//  div A=100, B=7 -> ready low 16 cycles, flag on cycle 17, arith_out=14, arith_hi=2
//   new requests are ignored while busy
//  div A=16'h00AB, B=0 -> next cycle div_zero=1, arith_out=16'hFFFF, arith_hi=16'h00AB
//  start div A=1000, B=3; drive RST low at cycle 8
//   -> all outputs 0, ready=1, no flag pulse
//   back-to-back add every cycle -> one flag pulse per request

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the multi-cycle arithmetic unit.
//   - ARITH_ADD/SUB/MUL/DIV : alu_fun opcode values driven by the ALU decoder
//   - arith_state_e         : control FSM encoding (ST_IDLE, ST_DIV, ST_DONE)
package arith_pkg;

    localparam logic [1:0] ARITH_ADD = 2'b00;
    localparam logic [1:0] ARITH_SUB = 2'b01;
    localparam logic [1:0] ARITH_MUL = 2'b10;
    localparam logic [1:0] ARITH_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } arith_state_e;

endpackage

// File: rtl/arith_unit_mc_if.sv
// Request/result bundle between the ALU decoder and arith_unit_mc.
//   arith_enable, alu_fun, A, B : request (master -> unit)
//   arith_ready                 : unit can take a request this cycle
//   arith_out, arith_hi         : low / high result words
//   carry_out, div_zero         : status, held between result pulses
//   arith_flag                  : one-cycle result-valid pulse
// master: the requester (ALU decoder). slave: the arithmetic unit.
interface arith_unit_mc_if #(
    parameter int Width = 16
);
    logic             arith_enable;
    logic [1:0]       alu_fun;
    logic [Width-1:0] A;
    logic [Width-1:0] B;
    logic             arith_ready;
    logic [Width-1:0] arith_out;
    logic [Width-1:0] arith_hi;
    logic             carry_out;
    logic             div_zero;
    logic             arith_flag;

    modport master (
        output arith_enable, alu_fun, A, B,
        input  arith_ready, arith_out, arith_hi, carry_out, div_zero, arith_flag
    );

    modport slave (
        input  arith_enable, alu_fun, A, B,
        output arith_ready, arith_out, arith_hi, carry_out, div_zero, arith_flag
    );
endinterface

// File: rtl/arith_div_seq.sv
// Iterative restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : load dividend/divisor and begin Width iterations
//   dividend,divisor: unsigned operands, sampled only on start
//   busy            : iterations in progress
//   done            : high during the cycle whose edge performs the last iteration
//   quo, rem        : result of the iteration performed at the coming edge;
//                     equal to the final quotient/remainder while done is high
// The caller must not assert start with divisor == 0.
module arith_div_seq #(
    parameter int Width = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [Width-1:0] dividend,
    input  logic [Width-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [Width-1:0] quo,
    output logic [Width-1:0] rem
);
    localparam int CNT_W = $clog2(Width + 1);

    logic [Width-1:0] quo_q, rem_q, div_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;

    logic [Width:0]   shifted;
    logic             fits;
    logic [Width-1:0] quo_nxt, rem_nxt;

    // {rem,quo} shifted left by one; the partial remainder needs one extra
    // bit before the trial subtraction, the result always fits in Width.
    always_comb begin
        shifted = {rem_q, quo_q[Width-1]};
        fits    = (shifted >= {1'b0, div_q});
        rem_nxt = fits ? Width'(shifted - {1'b0, div_q}) : shifted[Width-1:0];
        quo_nxt = {quo_q[Width-2:0], fits};
    end

    // Step outputs are exposed combinationally so the caller can register the
    // final result on the same edge as the last iteration.
    assign quo  = quo_nxt;
    assign rem  = rem_nxt;
    assign busy = busy_q;
    assign done = busy_q && (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            quo_q  <= dividend;
            rem_q  <= '0;
            div_q  <= divisor;
            cnt_q  <= CNT_W'(Width);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            quo_q <= quo_nxt;
            rem_q <= rem_nxt;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1))
                busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/arith_unit_mc.sv
// Multi-cycle arithmetic unit: add/sub/mul in one cycle, iterative div.
// Ports:
//   CLK  : clock, rising edge
//   RST  : asynchronous active-low reset
//   bus  : arith_unit_mc_if.slave (request, ready, results, flag)
// Results are registered; arith_flag pulses one cycle when they change.
// add/sub/mul: flag the cycle after accept, unit stays ready every cycle.
// div: ready drops for Width cycles, flag in the following (DONE) cycle,
//      where a new request may already be accepted. Div by zero returns
//      all ones / A with div_zero, with single-cycle latency.
// Build option: define ARITH_SAT_EN to saturate add/sub/mul results
// instead of wrapping; carry_out and arith_hi still report the true values.
module arith_unit_mc
    import arith_pkg::*;
#(
    parameter int Width = 16
) (
    input  logic           CLK,
    input  logic           RST,
    arith_unit_mc_if.slave bus
);

    arith_state_e     state;
    logic             ready_q, flag_q, carry_q, dz_q;
    logic [Width-1:0] out_q, hi_q;

    logic [Width:0]     sum, diff;
    logic [2*Width-1:0] prod;
    logic [Width-1:0]   op_lo, op_hi;
    logic               op_c;

    logic             accept, b_zero, start_div;
    logic             div_busy, div_done;
    logic [Width-1:0] div_quo, div_rem;

    assign accept    = bus.arith_enable & ready_q;
    assign b_zero    = (bus.B == '0);
    assign start_div = accept && (bus.alu_fun == ARITH_DIV) && !b_zero;

    // Single-cycle ops. The extra sum/diff bit is the carry / borrow.
    always_comb begin
        sum   = {1'b0, bus.A} + {1'b0, bus.B};
        diff  = {1'b0, bus.A} - {1'b0, bus.B};
        prod  = {{Width{1'b0}}, bus.A} * {{Width{1'b0}}, bus.B};
        op_lo = '0;
        op_hi = '0;
        op_c  = 1'b0;
        case (bus.alu_fun)
            ARITH_ADD: begin
                op_lo = sum[Width-1:0];
                op_c  = sum[Width];
`ifdef ARITH_SAT_EN
                if (sum[Width]) op_lo = '1;
`endif
            end
            ARITH_SUB: begin
                op_lo = diff[Width-1:0];
                op_c  = diff[Width];
`ifdef ARITH_SAT_EN
                if (diff[Width]) op_lo = '0;
`endif
            end
            ARITH_MUL: begin
                op_lo = prod[Width-1:0];
                op_hi = prod[2*Width-1:Width];
`ifdef ARITH_SAT_EN
                if (prod[2*Width-1:Width] != '0) op_lo = '1;
`endif
            end
            default: ;
        endcase
    end

    arith_div_seq #(.Width(Width)) u_div (
        .clk      (CLK),
        .rst_n    (RST),
        .start    (start_div),
        .dividend (bus.A),
        .divisor  (bus.B),
        .busy     (div_busy),
        .done     (div_done),
        .quo      (div_quo),
        .rem      (div_rem)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            flag_q  <= 1'b0;
            out_q   <= '0;
            hi_q    <= '0;
            carry_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            case (state)
                // DONE only differs from IDLE in that the div flag is up.
                ST_IDLE, ST_DONE: begin
                    flag_q <= 1'b0;
                    state  <= ST_IDLE;
                    if (accept) begin
                        if (bus.alu_fun != ARITH_DIV) begin
                            out_q   <= op_lo;
                            hi_q    <= op_hi;
                            carry_q <= op_c;
                            dz_q    <= 1'b0;
                            flag_q  <= 1'b1;
                        end else if (b_zero) begin
                            out_q   <= '1;
                            hi_q    <= bus.A;
                            carry_q <= 1'b0;
                            dz_q    <= 1'b1;
                            flag_q  <= 1'b1;
                        end else begin
                            ready_q <= 1'b0;
                            state   <= ST_DIV;
                        end
                    end
                end
                ST_DIV: begin
                    flag_q <= 1'b0;
                    if (div_done) begin
                        out_q   <= div_quo;
                        hi_q    <= div_rem;
                        carry_q <= 1'b0;
                        dz_q    <= 1'b0;
                        flag_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state   <= ST_DONE;
                    end else if (!div_busy) begin
                        // divider lost its operation: recover without a pulse
                        ready_q <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    flag_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.arith_ready = ready_q;
    assign bus.arith_out   = out_q;
    assign bus.arith_hi    = hi_q;
    assign bus.carry_out   = carry_q;
    assign bus.div_zero    = dz_q;
    assign bus.arith_flag  = flag_q;

endmodule

// File: tb/tb_arith_unit_mc.sv
// Randomized, self-checking bench for arith_unit_mc (Width=16).
// A behavioural model computes results with plain integer arithmetic and a
// latency countdown; a compare process checks every output each cycle.
// Directed sections pin the model with hand-computed literals.
module tb_arith_unit_mc;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   flag_cnt = 0;

    arith_unit_mc_if #(.Width(W)) bus ();
    arith_unit_mc #(.Width(W)) dut (.CLK(clk), .RST(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         c;
        logic         dz;
    } res_t;

    // Reference result from integer arithmetic.
    function automatic res_t ref_op(input logic [1:0] fun, input logic [W-1:0] a_in, input logic [W-1:0] b_in);
        res_t   r;
        longint a = longint'(a_in);
        longint b = longint'(b_in);
        longint m = longint'(1) << W;
        longint s;
        r = '0;
        case (fun)
            2'b00: begin
                s    = a + b;
                r.c  = (s >= m);
                r.lo = W'(s % m);
`ifdef ARITH_SAT_EN
                if (r.c) r.lo = W'(m - 1);
`endif
            end
            2'b01: begin
                r.c  = (a < b);
                r.lo = W'((a - b + m) % m);
`ifdef ARITH_SAT_EN
                if (r.c) r.lo = '0;
`endif
            end
            2'b10: begin
                s    = a * b;
                r.lo = W'(s % m);
                r.hi = W'(s / m);
`ifdef ARITH_SAT_EN
                if (s >= m) r.lo = W'(m - 1);
`endif
            end
            default: begin
                if (b == 0) begin
                    r.lo = W'(m - 1);
                    r.hi = a_in;
                    r.dz = 1'b1;
                end else begin
                    r.lo = W'(a / b);
                    r.hi = W'(a % b);
                end
            end
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic         m_ready = 1'b1;
    logic         m_flag  = 1'b0;
    logic         m_c     = 1'b0;
    logic         m_dz    = 1'b0;
    logic [W-1:0] m_out   = '0;
    logic [W-1:0] m_hi    = '0;
    int           m_wait  = 0;
    res_t         pend    = '0;
    res_t         req_res;

    always_comb req_res = ref_op(bus.alu_fun, bus.A, bus.B);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ready <= 1'b1;
            m_flag  <= 1'b0;
            m_c     <= 1'b0;
            m_dz    <= 1'b0;
            m_out   <= '0;
            m_hi    <= '0;
            m_wait  <= 0;
        end else begin
            m_flag <= 1'b0;
            if (m_wait > 1) begin
                m_wait <= m_wait - 1;
            end else if (m_wait == 1) begin
                m_wait  <= 0;
                m_out   <= pend.lo;
                m_hi    <= pend.hi;
                m_c     <= 1'b0;
                m_dz    <= 1'b0;
                m_flag  <= 1'b1;
                m_ready <= 1'b1;
            end else if (bus.arith_enable) begin
                if (bus.alu_fun == 2'b11 && bus.B != '0) begin
                    pend    <= req_res;
                    m_wait  <= W;
                    m_ready <= 1'b0;
                end else begin
                    m_out  <= req_res.lo;
                    m_hi   <= req_res.hi;
                    m_c    <= req_res.c;
                    m_dz   <= req_res.dz;
                    m_flag <= 1'b1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst) begin
            chk("ready", 32'(bus.arith_ready), 32'(m_ready));
            chk("flag",  32'(bus.arith_flag),  32'(m_flag));
            chk("out",   32'(bus.arith_out),   32'(m_out));
            chk("hi",    32'(bus.arith_hi),    32'(m_hi));
            chk("carry", 32'(bus.carry_out),   32'(m_c));
            chk("dz",    32'(bus.div_zero),    32'(m_dz));
            if (bus.arith_flag) flag_cnt++;
        end
    end

    task automatic req(input logic [1:0] fun, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.arith_enable = 1'b1;
        bus.alu_fun      = fun;
        bus.A            = a;
        bus.B            = b;
    endtask

    task automatic idle();
        bus.arith_enable = 1'b0;
    endtask

    initial begin
        int        low, fpos, base;
        logic [1:0] f;
        logic [W-1:0] a, b;
        res_t      mr;

        bus.arith_enable = 1'b0;
        bus.alu_fun      = 2'b00;
        bus.A            = '0;
        bus.B            = '0;

        // model pins
        mr = ref_op(2'b11, 16'd100, 16'd7);
        chk("model_div_q", 32'(mr.lo), 32'd14);
        chk("model_div_r", 32'(mr.hi), 32'd2);
        mr = ref_op(2'b10, 16'h1234, 16'h0100);
        chk("model_mul_hi", 32'(mr.hi), 32'h0012);

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_out",   32'(bus.arith_out),   32'h0);
        chk("rst_hi",    32'(bus.arith_hi),    32'h0);
        chk("rst_carry", 32'(bus.carry_out),   32'h0);
        chk("rst_dz",    32'(bus.div_zero),    32'h0);
        chk("rst_flag",  32'(bus.arith_flag),  32'h0);
        chk("rst_ready", 32'(bus.arith_ready), 32'h1);
        #2 rst = 1'b1;

        // add overflow
        @(negedge clk); req(2'b00, 16'hFFFF, 16'h0001);
        @(negedge clk); idle();
        chk("add_flag",  32'(bus.arith_flag), 32'h1);
`ifdef ARITH_SAT_EN
        chk("add_out",   32'(bus.arith_out),  32'hFFFF);
`else
        chk("add_out",   32'(bus.arith_out),  32'h0000);
`endif
        chk("add_carry", 32'(bus.carry_out),  32'h1);

        // sub borrow
        @(negedge clk); req(2'b01, 16'd5, 16'd7);
        @(negedge clk); idle();
`ifdef ARITH_SAT_EN
        chk("sub_out",   32'(bus.arith_out), 32'h0000);
`else
        chk("sub_out",   32'(bus.arith_out), 32'hFFFE);
`endif
        chk("sub_carry", 32'(bus.carry_out), 32'h1);

        // mul
        @(negedge clk); req(2'b10, 16'h1234, 16'h0100);
        @(negedge clk); idle();
        chk("mul_flag", 32'(bus.arith_flag), 32'h1);
        chk("mul_out",  32'(bus.arith_out),  32'h3400);
        chk("mul_hi",   32'(bus.arith_hi),   32'h0012);

        // div 100/7 with ignored requests while busy
        @(negedge clk); req(2'b11, 16'd100, 16'd7);
        low  = 0;
        fpos = 0;
        for (int k = 1; k <= 40 && fpos == 0; k++) begin
            @(negedge clk);
            if (k < 10) req(2'b00, W'($urandom), W'($urandom));
            else idle();
            if (!bus.arith_ready) low++;
            if (bus.arith_flag) fpos = k;
        end
        chk("div_ready_low", 32'(low), 32'd16);
        chk("div_flag_cyc",  32'(fpos), 32'd17);
        chk("div_q",         32'(bus.arith_out), 32'd14);
        chk("div_r",         32'(bus.arith_hi),  32'd2);

        // div by zero, presented in the DONE cycle
        req(2'b11, 16'h00AB, 16'h0000);
        @(negedge clk); idle();
        chk("dz_flag", 32'(bus.arith_flag), 32'h1);
        chk("dz_dz",   32'(bus.div_zero),   32'h1);
        chk("dz_out",  32'(bus.arith_out),  32'hFFFF);
        chk("dz_hi",   32'(bus.arith_hi),   32'h00AB);

        // reset in the middle of a div
        @(negedge clk); req(2'b11, 16'd1000, 16'd3);
        @(negedge clk); idle();
        repeat (7) @(negedge clk);
        chk("mid_ready_low", 32'(bus.arith_ready), 32'h0);
        #2 rst = 1'b0;
        #1;
        chk("ab_out",   32'(bus.arith_out),   32'h0);
        chk("ab_hi",    32'(bus.arith_hi),    32'h0);
        chk("ab_dz",    32'(bus.div_zero),    32'h0);
        chk("ab_flag",  32'(bus.arith_flag),  32'h0);
        chk("ab_ready", 32'(bus.arith_ready), 32'h1);
        @(negedge clk); #2 rst = 1'b1;
        #1 base = flag_cnt;
        repeat (20) @(negedge clk);
        #1;
        chk("ab_no_flag", 32'(flag_cnt - base), 32'd0);

        // back-to-back adds
        @(negedge clk);
        #1 base = flag_cnt;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            req(2'b00, W'($urandom), W'($urandom));
        end
        @(negedge clk); idle();
        repeat (3) @(negedge clk);
        #1;
        chk("b2b_flags", 32'(flag_cnt - base), 32'd8);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) < 7) begin
                f = 2'($urandom_range(0, 3));
                a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
                case ($urandom_range(0, 7))
                    0:       b = '0;
                    1:       b = W'($urandom_range(1, 15));
                    2:       b = 16'hFFFF;
                    default: b = W'($urandom);
                endcase
                req(f, a, b);
            end else begin
                idle();
            end
        end
        @(negedge clk); idle();
        repeat (25) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
